sound_sequencer: RTL and testbench
==================================

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter NOTE_TICKS, default 5_000_000, SHALL be the number of cycles each note sounds (>=1).
REQ-002 Parameter GAP_TICKS, default 1_000_000, SHALL be the number of silent cycles after each note (>=1).
REQ-003 Parameter DIV_UNIT, default 3125, SHALL be the cycles per half-period divider unit (>=1).
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 sound_signal  input  4  sound code from the sound mux; 4'b0000 = no request.
REQ-007 tone_out  output  1  square-wave audio drive to the audio unit.
REQ-008 playing  output  1  high while a melody is in progress (TONE or GAP state).
REQ-009 note_index  output  2  index (0-3) of the current note.
REQ-010 active_code  output  4  code of the melody being played; 0 when idle.

Function
REQ-011 Recognised codes SHALL be 4'b0001 (MONSTER) and 4'b1101 (SPACESHIP); any other code SHALL never start a melody.
REQ-012 Block SHALL register sound_signal every cycle into prev_code.
REQ-013 A request SHALL be accepted on the cycle where sound_signal != prev_code and sound_signal is a recognised code.
REQ-014 A held code SHALL NOT retrigger.
REQ-015 A return to 0 SHALL NOT stop a melody in progress.
REQ-016 FSM states SHALL be IDLE, TONE and GAP.
REQ-017 On acceptance, from any state, the next edge SHALL set state=TONE, note_index=0, active_code=sound_signal, tone_out=1, and clear both counters (latest request wins; the current melody is restarted).
REQ-018 Note half-period SHALL be div*DIV_UNIT cycles, with div taken from a fixed table:
  - MONSTER: 8, 6, 4, 2
  - SPACESHIP: 2, 4, 8, 16
REQ-019 In TONE, tone_out SHALL toggle every half-period cycles, with the first toggle half-period cycles after TONE entry.
REQ-020 TONE SHALL last exactly NOTE_TICKS cycles, then transition to GAP.
REQ-021 On entry to GAP, tone_out SHALL be forced 0 and the half-period counter cleared.
REQ-022 GAP SHALL last exactly GAP_TICKS cycles; then, if note_index<3, state=TONE, note_index+1, tone_out=1; else state=IDLE.
REQ-023 In IDLE: tone_out=0, playing=0, note_index=0, active_code=0.
REQ-024 playing SHALL be a registered output equal to (state != IDLE).
REQ-025 Duration counter SHALL be $clog2(max(NOTE_TICKS,GAP_TICKS))+1 bits wide.
REQ-026 Half-period counter SHALL be wide enough for 16*DIV_UNIT.
REQ-027 Neither counter SHALL wrap.
REQ-028 An acceptance in the same cycle as a TONE/GAP/IDLE transition SHALL take precedence over that transition.
REQ-029 Total melody length with no interruption SHALL be 4*(NOTE_TICKS+GAP_TICKS) cycles from the acceptance edge to playing=0.

Reset
REQ-030 While resetN=0, all of the following SHALL be forced immediately (asynchronously):
  - state=IDLE
  - tone_out=0, playing=0, note_index=0, active_code=0
  - prev_code=0, both counters=0
REQ-031 Reset asserted mid-melody SHALL abort the melody with no further output activity.
REQ-032 After release, a code already present on sound_signal SHALL be accepted on the first edge (prev_code=0).

Verification
All scenarios use NOTE_TICKS=20, GAP_TICKS=4, DIV_UNIT=1.
REQ-033 Reset then sound_signal=0001 for 1 cycle -> playing=1 for exactly 96 cycles; note_index steps 0,1,2,3; tone_out half-periods of 8, 6, 4, 2 cycles; tone_out=0 in each 4-cycle gap.
REQ-034 Hold sound_signal=1101 for 200 cycles -> exactly one melody (96 cycles); active_code=1101; half-periods 2, 4, 8, 16.
REQ-035 Start 0001, switch to 1101 during note 2 TONE -> next edge: note_index=0, active_code=1101, tone_out=1; melody restarts.
REQ-036 Apply sound_signal=0101 or 1111 -> playing stays 0 and tone_out stays 0.
REQ-037 Assert resetN=0 mid-note 1 with sound_signal=0001 held; release -> outputs go 0 immediately; after release, 0001 is re-accepted on the first edge.
REQ-038 Present 0001 on the final GAP cycle of note 3 -> restart takes precedence; playing does not drop to 0.

Source files
------------

// File: rtl/sound_sequencer.sv
// sound_sequencer: plays a four-note square-wave melody selected by a sound
// code. MONSTER (4'b0001) and SPACESHIP (4'b1101) are the only codes that
// start a melody. A new code restarts the melody immediately. Each note is a
// TONE phase followed by a silent GAP phase.
module sound_sequencer #(
    parameter int NOTE_TICKS = 5_000_000,
    parameter int GAP_TICKS  = 1_000_000,
    parameter int DIV_UNIT   = 3125
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] sound_signal,
    output logic       tone_out,
    output logic       playing,
    output logic [1:0] note_index,
    output logic [3:0] active_code
);

    localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int DW        = $clog2(MAX_TICKS) + 1;
    localparam int HW        = $clog2(16 * DIV_UNIT + 1);

    localparam logic [3:0] CODE_MONSTER   = 4'b0001;
    localparam logic [3:0] CODE_SPACESHIP = 4'b1101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TONE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [DW-1:0] NOTE_LAST = DW'(NOTE_TICKS - 1);
    localparam logic [DW-1:0] GAP_LAST  = DW'(GAP_TICKS - 1);

    logic [1:0]    state_reg, state_next;
    logic [3:0]    prev_code_reg, prev_code_next;
    logic [3:0]    active_code_reg, active_code_next;
    logic [1:0]    note_index_reg, note_index_next;
    logic          tone_reg, tone_next;
    logic          playing_reg, playing_next;
    logic [DW-1:0] dur_cnt_reg, dur_cnt_next;
    logic [HW-1:0] half_cnt_reg, half_cnt_next;

    // Half-period tables in clock cycles, one entry per note.
    logic [HW-1:0] hp_monster   [4];
    logic [HW-1:0] hp_spaceship [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hp_table
            // MONSTER descends 8,6,4,2; SPACESHIP ascends 2,4,8,16 (in DIV_UNITs).
            assign hp_monster[gi]   = HW'((8 - 2 * gi) * DIV_UNIT);
            assign hp_spaceship[gi] = HW'((2 << gi) * DIV_UNIT);
        end
    endgenerate

    logic [HW-1:0] half_period;
    logic [HW-1:0] half_last;
    logic          recognised;
    logic          accept;

    // Half-period of the current note and request detection.
    always_comb begin
        half_period = (active_code_reg == CODE_SPACESHIP) ? hp_spaceship[note_index_reg]
                                                          : hp_monster[note_index_reg];
        half_last   = half_period - HW'(1);
        recognised  = (sound_signal == CODE_MONSTER) || (sound_signal == CODE_SPACESHIP);
        accept      = recognised && (sound_signal != prev_code_reg);
    end

    // Next-state logic; an accepted request overrides any phase transition.
    always_comb begin
        state_next       = state_reg;
        prev_code_next   = sound_signal;
        active_code_next = active_code_reg;
        note_index_next  = note_index_reg;
        tone_next        = tone_reg;
        dur_cnt_next     = dur_cnt_reg;
        half_cnt_next    = half_cnt_reg;

        if (accept) begin
            state_next       = ST_TONE;
            active_code_next = sound_signal;
            note_index_next  = 2'd0;
            tone_next        = 1'b1;
            dur_cnt_next     = '0;
            half_cnt_next    = '0;
        end else begin
            case (state_reg)
                ST_TONE: begin
                    if (dur_cnt_reg == NOTE_LAST) begin
                        state_next    = ST_GAP;
                        tone_next     = 1'b0;
                        dur_cnt_next  = '0;
                        half_cnt_next = '0;
                    end else begin
                        dur_cnt_next = dur_cnt_reg + DW'(1);
                        if (half_cnt_reg == half_last) begin
                            tone_next     = ~tone_reg;
                            half_cnt_next = '0;
                        end else begin
                            half_cnt_next = half_cnt_reg + HW'(1);
                        end
                    end
                end
                ST_GAP: begin
                    tone_next = 1'b0;
                    if (dur_cnt_reg == GAP_LAST) begin
                        dur_cnt_next  = '0;
                        half_cnt_next = '0;
                        if (note_index_reg != 2'd3) begin
                            state_next      = ST_TONE;
                            note_index_next = note_index_reg + 2'd1;
                            tone_next       = 1'b1;
                        end else begin
                            state_next       = ST_IDLE;
                            note_index_next  = 2'd0;
                            active_code_next = 4'd0;
                        end
                    end else begin
                        dur_cnt_next = dur_cnt_reg + DW'(1);
                    end
                end
                ST_IDLE: begin
                    tone_next        = 1'b0;
                    note_index_next  = 2'd0;
                    active_code_next = 4'd0;
                    dur_cnt_next     = '0;
                    half_cnt_next    = '0;
                end
                default: begin
                    state_next       = ST_IDLE;
                    tone_next        = 1'b0;
                    note_index_next  = 2'd0;
                    active_code_next = 4'd0;
                    dur_cnt_next     = '0;
                    half_cnt_next    = '0;
                end
            endcase
        end

        playing_next = (state_next != ST_IDLE);
    end

    // State and output registers, cleared asynchronously by resetN.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg       <= ST_IDLE;
            prev_code_reg   <= 4'd0;
            active_code_reg <= 4'd0;
            note_index_reg  <= 2'd0;
            tone_reg        <= 1'b0;
            playing_reg     <= 1'b0;
            dur_cnt_reg     <= '0;
            half_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            prev_code_reg   <= prev_code_next;
            active_code_reg <= active_code_next;
            note_index_reg  <= note_index_next;
            tone_reg        <= tone_next;
            playing_reg     <= playing_next;
            dur_cnt_reg     <= dur_cnt_next;
            half_cnt_reg    <= half_cnt_next;
        end
    end

    assign tone_out    = tone_reg;
    assign playing     = playing_reg;
    assign note_index  = note_index_reg;
    assign active_code = active_code_reg;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed testbench for sound_sequencer with NOTE_TICKS=20, GAP_TICKS=4,
// DIV_UNIT=1. Each melody note spans 24 cycles: 20 TONE + 4 GAP.
module tb_sound_sequencer;

    logic       clk;
    logic       resetN;
    logic [3:0] sound_signal;
    logic       tone_out;
    logic       playing;
    logic [1:0] note_index;
    logic [3:0] active_code;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    sound_sequencer #(
        .NOTE_TICKS(20),
        .GAP_TICKS (4),
        .DIV_UNIT  (1)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .sound_signal(sound_signal),
        .tone_out    (tone_out),
        .playing     (playing),
        .note_index  (note_index),
        .active_code (active_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports every mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Half-period (in cycles) of note n of the given melody.
    function automatic int hp_of(input logic [3:0] code, input int n);
        int mon [4] = '{8, 6, 4, 2};
        int spc [4] = '{2, 4, 8, 16};
        return (code == 4'b1101) ? spc[n] : mon[n];
    endfunction

    // Called right after the acceptance edge has been sampled. Walks the
    // full 96-cycle melody, comparing each note's tone waveform as a 24-bit
    // pattern, then checks that the sequencer is idle.
    task automatic play_check(input logic [3:0] code, input string name);
        logic [23:0] obs;
        logic [23:0] exp;
        int          play_cycles;
        play_cycles = 0;
        check({name, ".active_code"}, 32'(active_code), 32'(code));
        for (int n = 0; n < 4; n++) begin
            obs = '0;
            exp = '0;
            for (int k = 0; k < 24; k++) begin
                if (k == 0)
                    check($sformatf("%s.note%0d.index", name, n), 32'(note_index), 32'(n));
                obs[k] = tone_out;
                exp[k] = (k < 20) && (((k / hp_of(code, n)) % 2) == 0);
                if (playing) play_cycles++;
                step();
            end
            check($sformatf("%s.note%0d.tone", name, n), 32'(obs), 32'(exp));
        end
        check({name, ".playing_cycles"}, 32'(play_cycles), 32'd96);
        check({name, ".end_playing"},    32'(playing),     32'd0);
        check({name, ".end_tone"},       32'(tone_out),    32'd0);
        check({name, ".end_active"},     32'(active_code), 32'd0);
    endtask

    initial begin
        int extra_play;
        int bad_tone;

        resetN       = 1'b0;
        sound_signal = 4'd0;
        #1;
        check("reset.playing", 32'(playing),     32'd0);
        check("reset.tone",    32'(tone_out),    32'd0);
        check("reset.index",   32'(note_index),  32'd0);
        check("reset.active",  32'(active_code), 32'd0);
        step();
        step();
        resetN = 1'b1;
        step();

        // MONSTER, one-cycle pulse.
        sound_signal = 4'b0001;
        step();
        sound_signal = 4'b0000;
        check("mon.start_tone", 32'(tone_out), 32'd1);
        play_check(4'b0001, "mon");

        // SPACESHIP held for 200 cycles: one melody only.
        sound_signal = 4'b1101;
        step();
        play_check(4'b1101, "spc_hold");
        extra_play = 0;
        for (int i = 0; i < 103; i++) begin
            if (playing) extra_play++;
            step();
        end
        check("spc_hold.no_retrigger", 32'(extra_play), 32'd0);
        sound_signal = 4'b0000;
        step();

        // MONSTER interrupted during note 2 TONE by SPACESHIP.
        sound_signal = 4'b0001;
        step();
        sound_signal = 4'b0000;
        for (int i = 0; i < 53; i++) step();
        check("intr.before_index", 32'(note_index), 32'd2);
        check("intr.before_tone",  32'(tone_out),   32'd0);
        sound_signal = 4'b1101;
        step();
        sound_signal = 4'b0000;
        check("intr.restart_tone",  32'(tone_out), 32'd1);
        check("intr.restart_play",  32'(playing),  32'd1);
        play_check(4'b1101, "intr");

        // Unrecognised codes never start a melody.
        extra_play = 0;
        bad_tone   = 0;
        sound_signal = 4'b0101;
        for (int i = 0; i < 30; i++) begin
            step();
            if (playing)  extra_play++;
            if (tone_out) bad_tone++;
        end
        sound_signal = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            step();
            if (playing)  extra_play++;
            if (tone_out) bad_tone++;
        end
        sound_signal = 4'b0000;
        check("badcode.playing_cycles", 32'(extra_play), 32'd0);
        check("badcode.tone_cycles",    32'(bad_tone),   32'd0);
        step();

        // Reset mid note 1 with MONSTER held, then re-accept on first edge.
        sound_signal = 4'b0001;
        step();
        for (int i = 0; i < 30; i++) step();
        check("rst.before_index", 32'(note_index), 32'd1);
        check("rst.before_play",  32'(playing),    32'd1);
        resetN = 1'b0;
        #1;
        check("rst.async_play",   32'(playing),     32'd0);
        check("rst.async_tone",   32'(tone_out),    32'd0);
        check("rst.async_index",  32'(note_index),  32'd0);
        check("rst.async_active", 32'(active_code), 32'd0);
        step();
        check("rst.held_play", 32'(playing), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        step();
        check("rst.reaccept_play", 32'(playing),  32'd1);
        check("rst.reaccept_tone", 32'(tone_out), 32'd1);
        play_check(4'b0001, "rst");
        sound_signal = 4'b0000;
        step();

        // Request on the final GAP cycle of note 3 wins over the IDLE move.
        sound_signal = 4'b0001;
        step();
        sound_signal = 4'b0000;
        for (int i = 0; i < 95; i++) step();
        check("last.before_index", 32'(note_index), 32'd3);
        check("last.before_play",  32'(playing),    32'd1);
        sound_signal = 4'b0001;
        step();
        sound_signal = 4'b0000;
        check("last.restart_play",  32'(playing),    32'd1);
        check("last.restart_tone",  32'(tone_out),   32'd1);
        play_check(4'b0001, "last");

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
